// File: rtl/core_pkg.sv
// ============================================================================
// Module      : core_pkg
// Description : Shared types and constants for the boot-time imem loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package core_pkg;

    typedef enum logic [1:0] {
        HDR0 = 2'd0,
        HDR1 = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } loader_state_t;

    localparam int HDR_BYTES          = 2;
    localparam int WORD_BYTES         = 4;
    localparam int DEFAULT_IMEM_DEPTH = 256;

endpackage

`default_nettype wire

// File: rtl/imem_ram.sv
// ============================================================================
// Module      : imem_ram
// Description : DEPTH x DWIDTH RAM, synchronous write, asynchronous read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_ram #(
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 256,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DWIDTH-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [DWIDTH-1:0] o_rdata
);

    logic [DWIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// Module      : imem_loader
// Description : Streams a length-prefixed byte image into instruction RAM,
//               holds the core in reset while loading, then serves fetches.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader
    import core_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int DEPTH  = DEFAULT_IMEM_DEPTH,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              load_start,
    input  logic [DWIDTH-1:0] core_addr,
    output logic [DWIDTH-1:0] core_rdata,
    output logic              core_rst,
    output logic              load_done,
    output logic              load_err,
    output logic [15:0]       words_loaded
);

    localparam int LANE_W = $clog2(WORD_BYTES);
    localparam int HOLD_W = 8 * (WORD_BYTES - 1);

    loader_state_t           r_state;
    logic [LANE_W-1:0]       r_lane;
    logic [15:0]             r_wcnt;
    logic [15:0]             r_count;
    logic [15:0]             r_words;
    logic [HOLD_W-1:0]       r_hold;
    logic                    r_err;

    logic                    w_hs;
    logic                    w_last_lane;
    logic                    w_wcnt_ok;
    logic                    w_we;
    logic [15:0]             w_hdr_n;
    logic [DWIDTH-1:0]       w_wdata;
    logic [AW-1:0]           w_ridx;
    logic [DWIDTH-1:0]       w_ram_rdata;
    logic                    w_unused_addr;

    assign in_ready    = (r_state != DONE) && !load_start;
    assign w_hs        = in_valid && in_ready;
    assign w_last_lane = (r_lane == LANE_W'(WORD_BYTES - 1));
    assign w_wcnt_ok   = (32'(r_wcnt) < 32'(DEPTH));
    assign w_hdr_n     = {in_data, r_count[7:0]};
    assign w_we        = w_hs && (r_state == DATA) && w_last_lane && w_wcnt_ok;
    assign w_wdata     = DWIDTH'({in_data, r_hold});

    always_ff @(posedge clk) begin
        if (rst || load_start) begin
            r_state <= HDR0;
            r_lane  <= '0;
            r_wcnt  <= '0;
            r_count <= '0;
            r_words <= '0;
            r_hold  <= '0;
            r_err   <= 1'b0;
        end else if (w_hs) begin
            case (r_state)
                HDR0: begin
                    r_count <= {8'd0, in_data};
                    r_state <= HDR1;
                end
                HDR1: begin
                    r_count <= w_hdr_n;
                    r_err   <= (32'(w_hdr_n) > 32'(DEPTH));
                    r_state <= (w_hdr_n == 16'd0) ? DONE : DATA;
                end
                DATA: begin
                    r_lane <= r_lane + 1'b1;
                    if (!w_last_lane) begin
                        // Little-endian: earliest byte ends up in the low lane
                        r_hold <= {in_data, r_hold[HOLD_W-1:8]};
                    end else begin
                        r_wcnt <= r_wcnt + 16'd1;
                        if (32'(r_words) < 32'(DEPTH)) begin
                            r_words <= r_words + 16'd1;
                        end
                        if (r_wcnt == r_count - 16'd1) begin
                            r_state <= DONE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    imem_ram #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wcnt[AW-1:0]),
        .i_wdata (w_wdata),
        .i_raddr (w_ridx),
        .o_rdata (w_ram_rdata)
    );

    // RAM is never cleared; words beyond the current load are masked to zero
    assign w_ridx        = core_addr[AW+1:2];
    assign core_rdata    = (32'(w_ridx) < 32'(r_words)) ? w_ram_rdata : '0;
    assign w_unused_addr = ^{core_addr[DWIDTH-1:AW+2], core_addr[1:0]};

    assign core_rst      = (r_state != DONE);
    assign load_done     = (r_state == DONE);
    assign load_err      = r_err;
    assign words_loaded  = r_words;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// Module      : tb_imem_loader
// Description : Randomised self-checking bench for imem_loader with a
//               byte-position reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_loader;

    localparam int DEPTH = 4;

    logic        clk        = 1'b0;
    logic        rst        = 1'b1;
    logic        in_valid   = 1'b0;
    logic [7:0]  in_data    = 8'd0;
    logic        load_start = 1'b0;
    logic [31:0] core_addr  = 32'd0;
    logic        in_ready;
    logic [31:0] core_rdata;
    logic        core_rst;
    logic        load_done;
    logic        load_err;
    logic [15:0] words_loaded;

    always #5 clk = ~clk;

    imem_loader #(
        .DWIDTH (32),
        .DEPTH  (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .load_start   (load_start),
        .core_addr    (core_addr),
        .core_rdata   (core_rdata),
        .core_rst     (core_rst),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: position within the current stream decides every output
    int          pos   = 0;
    int          n_hdr = 0;
    logic [7:0]  nlo   = 8'd0;
    logic [31:0] wbuf  = 32'd0;
    logic [31:0] mmem [DEPTH];
    bit          chk_en = 1'b0;

    function automatic bit m_done();
        return (pos >= 2) && (pos == 2 + 4 * n_hdr);
    endfunction

    function automatic int m_words();
        int w;
        if (pos < 2) return 0;
        w = (pos - 2) / 4;
        return (w > DEPTH) ? DEPTH : w;
    endfunction

    always @(posedge clk) begin : model
        int d;
        if (rst || load_start) begin
            pos   = 0;
            n_hdr = 0;
        end else if (in_valid && !m_done()) begin
            if (pos == 0) begin
                nlo = in_data;
            end else if (pos == 1) begin
                n_hdr = int'({in_data, nlo});
            end else begin
                d = pos - 2;
                wbuf[8 * (d % 4) +: 8] = in_data;
                if ((d % 4 == 3) && (d / 4 < DEPTH)) mmem[d / 4] = wbuf;
            end
            pos++;
        end
        chk_en = 1'b1;
    end

    always @(negedge clk) begin : compare
        int idx;
        if (chk_en) begin
            check("in_ready", {31'd0, in_ready}, {31'd0, !m_done() && !load_start});
            check("core_rst", {31'd0, core_rst}, {31'd0, !m_done()});
            check("load_done", {31'd0, load_done}, {31'd0, m_done()});
            check("load_err", {31'd0, load_err}, {31'd0, (pos >= 2) && (n_hdr > DEPTH)});
            check("words_loaded", {16'd0, words_loaded}, 32'(m_words()));
            idx = int'((core_addr >> 2) % DEPTH);
            check("core_rdata", core_rdata, (idx < m_words()) ? mmem[idx] : 32'd0);
        end
    end

    task automatic step(input logic v, input logic [7:0] d, input logic ls, input logic r);
        in_valid   = v;
        in_data    = d;
        load_start = ls;
        rst        = r;
        core_addr  = $urandom;
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        load_start = 1'b0;
        rst        = 1'b0;
    endtask

    task automatic send(input logic [7:0] d);
        step(1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic send_gappy(input logic [7:0] d);
        while ($urandom_range(0, 2) == 0) step(1'b0, 8'($urandom), 1'b0, 1'b0);
        step(1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic rd(input string name, input logic [31:0] addr, input logic [31:0] exp);
        @(posedge clk);
        #1;
        core_addr = addr;
        #1;
        check(name, core_rdata, exp);
    endtask

    logic [7:0] s1 [10];
    logic [7:0] bb [20];
    logic [7:0] rb [12];

    initial begin
        s1 = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h20, 8'h08, 8'h00, 8'h00, 8'hAC};

        // Reset state
        step(1'b0, 8'd0, 1'b0, 1'b1);
        step(1'b0, 8'd0, 1'b0, 1'b1);
        core_addr = 32'd0;
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_core_rst", {31'd0, core_rst}, 32'd1);
        check("rst_load_done", {31'd0, load_done}, 32'd0);
        check("rst_load_err", {31'd0, load_err}, 32'd0);
        check("rst_words", {16'd0, words_loaded}, 32'd0);
        check("rst_rdata", core_rdata, 32'd0);

        // Two-word image
        for (int i = 0; i < 10; i++) begin
            send(s1[i]);
            if (i == 8) check("t1_done_early", {31'd0, load_done}, 32'd0);
            if (i == 9) check("t1_done_10th", {31'd0, load_done}, 32'd1);
        end
        rd("t1_addr0", 32'd0, 32'h20000013);
        rd("t1_addr4", 32'd4, 32'hAC000008);
        rd("t1_addr8", 32'd8, 32'd0);

        // Zero-length image
        step(1'b0, 8'd0, 1'b1, 1'b0);
        send(8'h00);
        check("t2_not_done", {31'd0, load_done}, 32'd0);
        send(8'h00);
        check("t2_done", {31'd0, load_done}, 32'd1);
        check("t2_err", {31'd0, load_err}, 32'd0);
        rd("t2_addr0", 32'd0, 32'd0);
        rd("t2_addr4", 32'd4, 32'd0);

        // Oversized image: 5 words into DEPTH=4
        step(1'b0, 8'd0, 1'b1, 1'b0);
        send(8'h05);
        send(8'h00);
        check("t3_err", {31'd0, load_err}, 32'd1);
        for (int i = 0; i < 20; i++) bb[i] = 8'($urandom);
        for (int i = 0; i < 20; i++) begin
            send(bb[i]);
            if (i == 18) check("t3_done_early", {31'd0, load_done}, 32'd0);
            if (i == 19) check("t3_done", {31'd0, load_done}, 32'd1);
        end
        check("t3_words", {16'd0, words_loaded}, 32'd4);
        rd("t3_word3", 32'd12, {bb[15], bb[14], bb[13], bb[12]});

        // Three-word image, gapless then with random gaps
        for (int i = 0; i < 12; i++) rb[i] = 8'($urandom);
        for (int pass = 0; pass < 2; pass++) begin
            step(1'b0, 8'd0, 1'b1, 1'b0);
            send(8'h03);
            send(8'h00);
            for (int i = 0; i < 12; i++) begin
                if (pass == 0) send(rb[i]);
                else send_gappy(rb[i]);
            end
            for (int w = 0; w < 3; w++)
                rd("t4_word", 32'(4 * w), {rb[4*w+3], rb[4*w+2], rb[4*w+1], rb[4*w]});
        end

        // Restart mid-DATA with a byte offered alongside load_start
        step(1'b0, 8'd0, 1'b1, 1'b0);
        send(8'h02);
        send(8'h00);
        for (int i = 0; i < 4; i++) send(8'($urandom));
        in_valid   = 1'b1;
        in_data    = 8'h55;
        load_start = 1'b1;
        #1;
        check("t5_ready_low", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        load_start = 1'b0;
        send(8'h01);
        send(8'h00);
        send(8'hDE);
        send(8'hAD);
        send(8'hBE);
        send(8'hEF);
        rd("t5_addr0", 32'd0, 32'hEFBEADDE);
        rd("t5_addr4", 32'd4, 32'd0);

        // rst while in DONE
        step(1'b0, 8'd0, 1'b0, 1'b1);
        check("t6_core_rst", {31'd0, core_rst}, 32'd1);
        check("t6_done", {31'd0, load_done}, 32'd0);
        check("t6_words", {16'd0, words_loaded}, 32'd0);
        check("t6_ready", {31'd0, in_ready}, 32'd1);

        // Random loads with gaps and occasional restarts
        for (int k = 0; k < 25; k++) begin
            int n;
            n = $urandom_range(0, 6);
            step(1'b0, 8'd0, 1'b1, 1'b0);
            send_gappy(8'(n));
            send_gappy(8'h00);
            for (int i = 0; i < 4 * n; i++) begin
                if ($urandom_range(0, 59) == 0) step(1'b1, 8'($urandom), 1'b1, 1'b0);
                send_gappy(8'($urandom));
            end
            for (int i = 0; i < 6; i++) step(1'b0, 8'd0, 1'b0, 1'b0);
        end

        @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction-memory writer and read responder for the single-cycle core. It accepts a byte stream over a valid/ready handshake, packs bytes little-endian into 32-bit instruction words, and writes them into its internal instruction RAM. It holds the core in reset until loading completes, then serves the core's combinational instruction-fetch reads in place of a preloaded imem.

## Interface
Parameters:
- DWIDTH, 32: instruction/word width and core address width.
- DEPTH, 256: RAM depth in words; power of two, at most 65535.
- AW, $clog2(DEPTH): word-index width (derived).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  byte-stream source has a byte.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte; a handshake is in_valid && in_ready at a rising edge.
- load_start  input  1  single-cycle pulse that restarts loading from any state.
- core_addr  input  DWIDTH  core fetch byte address (pc).
- core_rdata  output  DWIDTH  fetched instruction; combinational from core_addr.
- core_rst  output  1  reset to the core; high while loading.
- load_done  output  1  registered; high in DONE.
- load_err  output  1  registered; header count exceeded DEPTH.
- words_loaded  output  16  words written so far in the current load.

## Operation
- Stream format: 2-byte header word count N (low byte first), then N words of 4 bytes each, low byte first.
- FSM states: HDR0 (accept count low byte) -> HDR1 (accept count high byte) -> DATA (accept 4N bytes) -> DONE.
- HDR1 handshake: if N == 0, go to DONE; otherwise go to DATA. In the same edge, set load_err if N > DEPTH.
- DATA uses a 2-bit byte lane counter and a 16-bit word counter.
  - Bytes 0–2 go into a shift/holding register.
  - The lane-3 handshake writes {b3,b2,b1,b0} to RAM[word counter], but only if word counter < DEPTH.
  - words_loaded increments on that edge, saturating at DEPTH.
  - The word counter increments unsaturated.
  - The FSM goes to DONE when the word counter reaches N-1 and lane 3 is accepted.
- If N > DEPTH, all 4N bytes are still consumed. Words past DEPTH are dropped.
- in_ready = (state != DONE) && !load_start, combinational.
- core_rst = (state != DONE), registered through the state.
- core_rdata returns RAM[core_addr[AW+1:2]] when that index < words_loaded. Otherwise it returns 0.
- core_addr[1:0] is ignored, and so are core_addr bits above AW+1.
- load_start, from any state:
  - next state HDR0;
  - clears the counters, words_loaded, load_err, and the holding register;
  - re-asserts core_rst from the next cycle.
- rst has the same effect as load_start. RAM contents are not cleared by rst or load_start; stale words are masked by the words_loaded compare.

## Timing
- Values after reset: state HDR0, in_ready 1, core_rst 1, load_done 0, load_err 0, words_loaded 0, core_rdata 0.
- A RAM write on edge k is visible on core_rdata from edge k (same-cycle combinational read after the edge).
- load_done rises and core_rst falls on the edge that accepts the final byte. The core's first fetch (pc 0 after its own reset) occurs the following cycle.
- A zero-length load reaches DONE on the HDR1 handshake edge.
- in_valid may toggle freely; bubbles stall the FSM without losing lane position.
- load_start asserted together with in_valid: no handshake occurs, because in_ready is 0. The byte is not consumed.
- load_start in DONE: leaves DONE on the next edge; in_ready rises after that edge.
- rst has priority over load_start, and both have priority over handshakes.

## Structure
- Shared package core_pkg:
  - loader state enum {HDR0, HDR1, DATA, DONE};
  - HDR_BYTES = 2;
  - WORD_BYTES = 4;
  - DEFAULT_IMEM_DEPTH = 256.
- Sub-module imem_ram: DEPTH x DWIDTH, one synchronous write port, one asynchronous read port. It is instantiated once. The FSM, packing, and masking live in imem_loader.

## Test plan
- Reset then stream 02 00, 13 00 00 20, 08 00 00 AC:
  - load_done rises on the 10th handshake;
  - core_addr 0 -> 0x20000013;
  - core_addr 4 -> 0xAC000008;
  - core_addr 8 -> 0.
- Header 00 00 -> DONE on the 2nd handshake; core_rdata 0 for all addresses; load_err 0.
- DEPTH=4, header 05 00, 20 bytes:
  - load_err 1 after the 2nd handshake;
  - words_loaded saturates at 4;
  - all 22 bytes are accepted;
  - RAM[3] holds the 4th word.
- Random in_valid gaps during a 3-word load -> words identical to the gapless run; core_rst stays 1 until the final byte.
- load_start pulsed mid-DATA (after 6 bytes) together with in_valid:
  - that byte is not accepted;
  - the next bytes 01 00 DE AD BE EF load one word;
  - core_addr 0 -> 0xEFBEADDE;
  - core_addr 4 -> 0.
- rst asserted in DONE -> next cycle core_rst 1, load_done 0, words_loaded 0, in_ready 1.
